// File: rtl/l2_types_pkg.sv
// Shared types and constants for the L2 arbiter and the L1/L2 line datapaths.
// Pure declarations: no logic, no latency, no flow control.
package l2_types_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef logic [LINE_W-1:0] lc3b_line_t;

endpackage

// File: rtl/l2_arbiter_mux.sv
// Combinational steering of the granted master onto the L2 port and of L2 data back to it.
// Zero latency; the ungranted master sees resp and rdata forced to 0.
module l2_arbiter_mux
  import l2_types_pkg::*;
#(
  parameter int ADDR_W = l2_types_pkg::ADDR_W,
  parameter int LINE_W = l2_types_pkg::LINE_W
) (
  input  arb_state_t        state_i,
  input  logic              i_read_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [LINE_W-1:0] d_wdata_i,
  input  logic [LINE_W-1:0] l2_rdata_i,
  input  logic              l2_resp_i,
  output logic [LINE_W-1:0] i_rdata_o,
  output logic              i_resp_o,
  output logic [LINE_W-1:0] d_rdata_o,
  output logic              d_resp_o,
  output logic              l2_read_o,
  output logic              l2_write_o,
  output logic [ADDR_W-1:0] l2_addr_o,
  output logic [LINE_W-1:0] l2_wdata_o
);

  always_comb begin
    i_rdata_o  = '0;
    i_resp_o   = 1'b0;
    d_rdata_o  = '0;
    d_resp_o   = 1'b0;
    l2_read_o  = 1'b0;
    l2_write_o = 1'b0;
    l2_addr_o  = '0;
    l2_wdata_o = '0;
    case (state_i)
      SERVE_I: begin
        l2_read_o = i_read_i;
        l2_addr_o = i_addr_i;
        i_rdata_o = l2_rdata_i;
        i_resp_o  = l2_resp_i & i_read_i;
      end
      SERVE_D: begin
        // A simultaneous read+write is treated as a write.
        l2_read_o  = d_read_i & ~d_write_i;
        l2_write_o = d_write_i;
        l2_addr_o  = d_addr_i;
        l2_wdata_o = d_wdata_i;
        d_rdata_o  = l2_rdata_i;
        d_resp_o   = l2_resp_i & (d_read_i | d_write_i);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter between L1 I-cache and D-cache in front of L2; one IDLE decision cycle per grant.
// Requests are held by masters until resp; the losing master simply waits, no preemption.
module l2_arbiter
  import l2_types_pkg::*;
#(
  parameter int ADDR_W = l2_types_pkg::ADDR_W,
  parameter int LINE_W = l2_types_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       i_req, d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          state_d = (last_grant_q == GRANT_D) ? SERVE_I : SERVE_D;
        end else if (i_req) begin
          state_d = SERVE_I;
        end else if (d_req) begin
          state_d = SERVE_D;
        end
      end
      SERVE_I: begin
        // A dropped request aborts without touching fairness history.
        if (!i_req) begin
          state_d = IDLE;
        end else if (l2_resp) begin
          state_d      = IDLE;
          last_grant_d = GRANT_I;
        end
      end
      SERVE_D: begin
        if (!d_req) begin
          state_d = IDLE;
        end else if (l2_resp) begin
          state_d      = IDLE;
          last_grant_d = GRANT_D;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  l2_arbiter_mux #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) u_mux (
    .state_i   (state_q),
    .i_read_i  (i_read),
    .i_addr_i  (i_addr),
    .d_read_i  (d_read),
    .d_write_i (d_write),
    .d_addr_i  (d_addr),
    .d_wdata_i (d_wdata),
    .l2_rdata_i(l2_rdata),
    .l2_resp_i (l2_resp),
    .i_rdata_o (i_rdata),
    .i_resp_o  (i_resp),
    .d_rdata_o (d_rdata),
    .d_resp_o  (d_resp),
    .l2_read_o (l2_read),
    .l2_write_o(l2_write),
    .l2_addr_o (l2_addr),
    .l2_wdata_o(l2_wdata)
  );

endmodule
